// File: rtl/reg_map.sv
// Control register bank for the 10-band equalizer: ten Q4.4 gain codes widened to
// Q5.8 gains, one configuration byte, and a combinational byte read-back.
module reg_map #(
  parameter int unsigned GAIN_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [7:0]            addr,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  output logic [7:0]            configuration,
  output logic [GAIN_WIDTH-1:0] gain_1,
  output logic [GAIN_WIDTH-1:0] gain_2,
  output logic [GAIN_WIDTH-1:0] gain_3,
  output logic [GAIN_WIDTH-1:0] gain_4,
  output logic [GAIN_WIDTH-1:0] gain_5,
  output logic [GAIN_WIDTH-1:0] gain_6,
  output logic [GAIN_WIDTH-1:0] gain_7,
  output logic [GAIN_WIDTH-1:0] gain_8,
  output logic [GAIN_WIDTH-1:0] gain_9,
  output logic [GAIN_WIDTH-1:0] gain_10
);

  localparam int unsigned NUM_BANDS   = 10;
  localparam logic [7:0]  CONFIG_ADDR = 8'h0A;
  localparam logic [7:0]  GAIN_RESET  = 8'h10;
  localparam logic [7:0]  CONFIG_RESET = 8'h00;

  logic [7:0] gain_code [NUM_BANDS];
  logic [7:0] config_q;

  // Register file; reset takes priority over a coincident write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        gain_code[i] <= GAIN_RESET;
      end
      config_q <= CONFIG_RESET;
    end else if (we) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        if (addr == 8'(i)) begin
          gain_code[i] <= data_in;
        end
      end
      if (addr == CONFIG_ADDR) begin
        config_q <= data_in;
      end
    end
  end

  // Read-back mux; unmapped addresses return zero
  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_BANDS; i++) begin
      if (addr == 8'(i)) begin
        data_out = gain_code[i];
      end
    end
    if (addr == CONFIG_ADDR) begin
      data_out = config_q;
    end
  end

  // Q4.4 code to Q5.8 gain: shift left by four, top bit stays zero
  function automatic logic [GAIN_WIDTH-1:0] to_gain(input logic [7:0] code);
    return GAIN_WIDTH'({1'b0, code, 4'b0000});
  endfunction

  assign configuration = config_q;
  assign gain_1  = to_gain(gain_code[0]);
  assign gain_2  = to_gain(gain_code[1]);
  assign gain_3  = to_gain(gain_code[2]);
  assign gain_4  = to_gain(gain_code[3]);
  assign gain_5  = to_gain(gain_code[4]);
  assign gain_6  = to_gain(gain_code[5]);
  assign gain_7  = to_gain(gain_code[6]);
  assign gain_8  = to_gain(gain_code[7]);
  assign gain_9  = to_gain(gain_code[8]);
  assign gain_10 = to_gain(gain_code[9]);

endmodule

// File: tb/tb_reg_map.sv
// Self-checking bench for reg_map: directed plan followed by randomized traffic,
// compared against an array-based model of the register map.
module tb_reg_map;

  localparam int unsigned GW = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we = 1'b0;
  logic [7:0]    addr = '0;
  logic [7:0]    data_in = '0;
  logic [7:0]    data_out;
  logic [7:0]    configuration;
  logic [GW-1:0] gain [10];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: plain integers
  int gc_m [10];
  int cfg_m;

  reg_map #(.GAIN_WIDTH(GW)) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .configuration(configuration),
    .gain_1(gain[0]), .gain_2(gain[1]), .gain_3(gain[2]), .gain_4(gain[3]),
    .gain_5(gain[4]), .gain_6(gain[5]), .gain_7(gain[6]), .gain_8(gain[7]),
    .gain_9(gain[8]), .gain_10(gain[9])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int model_read(input int a);
    if (a < 10) return gc_m[a];
    if (a == 10) return cfg_m;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 10; i++) gc_m[i] = 16;
    cfg_m = 0;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 10; i++)
      check($sformatf("%s gain_%0d", tag, i + 1), int'(gain[i]), gc_m[i] * 16);
    check({tag, " configuration"}, int'(configuration), cfg_m);
    check($sformatf("%s data_out@%0h", tag, addr), int'(data_out), model_read(int'(addr)));
  endtask

  // Drive one cycle away from the edge, let the edge capture, update model, check
  task automatic cycle(input logic r, input logic w, input logic [7:0] a,
                       input logic [7:0] d, input string tag);
    @(negedge clk);
    rst = r; we = w; addr = a; data_in = d;
    @(posedge clk);
    #1;
    if (r) model_reset();
    else if (w) begin
      if (int'(a) < 10) gc_m[int'(a)] = int'(d);
      else if (int'(a) == 10) cfg_m = int'(d);
    end
    check_all(tag);
  endtask

  // Combinational read-back sweep with writes disabled
  task automatic read_sweep(input string tag);
    logic [7:0] addrs [14];
    for (int i = 0; i < 12; i++) addrs[i] = 8'(i);
    addrs[12] = 8'h80;
    addrs[13] = 8'hFF;
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    for (int i = 0; i < 14; i++) begin
      addr = addrs[i];
      data_in = 8'($urandom);
      #0.5;
      check($sformatf("%s read@%0h", tag, addrs[i]), int'(data_out), model_read(int'(addrs[i])));
    end
  endtask

  initial begin
    int codes [10] = '{1, 5, 9, 13, 17, 21, 25, 29, 32, 34};
    model_reset();

    cycle(1'b1, 1'b0, 8'h00, 8'h00, "reset");
    cycle(1'b0, 1'b0, 8'h0B, 8'h00, "post_reset");

    for (int i = 0; i < 10; i++)
      cycle(1'b0, 1'b1, 8'(i), 8'(codes[i]), $sformatf("wr_band%0d", i + 1));

    cycle(1'b0, 1'b1, 8'h0A, 8'hA5, "wr_config");
    cycle(1'b0, 1'b1, 8'h00, 8'hFF, "gain_max");
    cycle(1'b0, 1'b1, 8'h01, 8'h00, "gain_mute");
    cycle(1'b0, 1'b1, 8'h0B, 8'h77, "unmapped_0b");
    cycle(1'b0, 1'b1, 8'hFF, 8'h77, "unmapped_ff");
    read_sweep("sweep1");

    cycle(1'b0, 1'b0, 8'h03, 8'h99, "we_low_a");
    cycle(1'b0, 1'b0, 8'h0A, 8'h12, "we_low_b");
    cycle(1'b1, 1'b1, 8'h03, 8'h40, "rst_wins");
    cycle(1'b0, 1'b1, 8'h05, 8'hC3, "wr_after_rst");
    cycle(1'b0, 1'b1, 8'h0A, 8'h3C, "wr_cfg2");
    cycle(1'b1, 1'b0, 8'h05, 8'h00, "rst_mid");

    // Random traffic: mostly mapped addresses, occasional full-range and reset
    for (int n = 0; n < 400; n++) begin
      logic       r, w;
      logic [7:0] a, d;
      r = ($urandom_range(0, 31) == 0);
      w = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      d = 8'($urandom);
      cycle(r, w, a, d, $sformatf("rand%0d", n));
    end
    read_sweep("sweep2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_map.md
Name: reg_map

Overview:
- Byte-wide, write-mostly control register bank for the 10-band digital audio equalizer.
- Host/bus logic writes one 8-bit gain code per band plus one 8-bit configuration byte.
- The block holds each value in a flop and drives it continuously to the band filters as a Q5.8 unsigned gain, plus a configuration byte to the datapath.
- Also provides a combinational byte read-back.

Parameters:
- GAIN_WIDTH, 13, width of each gain output. Format is Q5.8 unsigned: 5 integer bits, 8 fraction bits. Only 13 is required to be supported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- we  input  1  write enable, sampled on the rising edge of clk.
- addr  input  8  register address.
- data_in  input  8  write data.
- data_out  output  8  combinational read-back of the register selected by addr.
- configuration  output  8  configuration register contents.
- gain_1 .. gain_10  output  GAIN_WIDTH each  Q5.8 gain for band 1 (lowest) .. band 10 (highest).

Behaviour:
- Clock and reset:
  - One clock: clk. Reset is synchronous and active-high (rst).
  - On a rising edge with rst=1, every register loads its reset value. Reset has priority over a simultaneous write.
- Address map (8-bit address):
  - 0x00..0x09 = band gain code registers GC1..GC10; addr 0x00 maps to gain_1, 0x09 to gain_10.
  - 0x0A = CONFIG.
  - 0x0B..0xFF are unmapped.
- Write timing:
  - On a rising edge with rst=0 and we=1, the register at addr loads data_in.
  - Writes to unmapped addresses are ignored with no side effects.
  - When we=0, all registers hold their value.
  - The new value appears on the outputs immediately after the capturing edge (one-edge write latency). There is no handshake and no busy state; back-to-back writes on consecutive cycles are all accepted.
- Gain code format:
  - The 8-bit code is unsigned Q4.4.
  - Conversion: gain_n = {1'b0, GCn[7:0], 4'b0000}, i.e. gain value = code × 16 in Q5.8 LSBs.
  - Range: code 0x00 gives 0 (mute); code 0xFF gives 4080 (15.9375). Bit 12 of every gain output is always 0. No saturation or rounding is needed.
  - Outputs are driven directly from the registers through wiring only; there is no extra pipeline stage.
- Reset values:
  - GC1..GC10 reset to 0x10, so every gain_n = 256 (unity gain, flat response).
  - CONFIG resets to 0x00, so configuration = 0x00.
  - data_out after reset is determined by addr alone.
- Read-back:
  - data_out = byte at addr (GCn or CONFIG); unmapped addresses read 0x00.
  - Read-back is purely combinational and independent of we.
  - A write to the addressed register is reflected on data_out after the capturing edge.
- Reset mid-operation: a write coincident with rst=1 is discarded; all registers take their reset values.

Test Plan:
- Apply rst=1 for one edge, then rst=0 -> every gain_1..gain_10 = 256; configuration = 0x00; data_out at addr 0x0B = 0x00.
- Single-cycle writes with we=1 of codes 1, 5, 9, 13, 17, 21, 25, 29, 32, 34 to addresses 0..9 -> gain_1..gain_10 = 16, 80, 144, 208, 272, 336, 400, 464, 512, 544 after each capturing edge; other bands are unchanged at each step.
- Write 0xA5 to addr 0x0A -> configuration = 0xA5; data_out with addr=0x0A = 0xA5. Write 0xFF to addr 0x00 -> gain_1 = 4080. Write 0x00 to addr 0x01 -> gain_2 = 0.
- Write 0x77 to addr 0x0B and to addr 0xFF -> no output changes; data_out reads 0x00 at both addresses.
- Hold we=1 with rst=1 while writing 0x40 to addr 0x03 -> gain_4 = 256 (reset wins). With we=0, change addr/data_in -> no register changes.
- After programming non-default values, assert rst for one edge -> all gains return to 256 and configuration to 0x00 on that edge.
